// File: rtl/sixtyfourbit_seq_mul.sv
// Sequential RV64M multiplier: one shift-add step per clock over 64 iterations,
// then a sign fix-up cycle and a one-cycle done pulse.

module sixtyfourbit_lca (
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        cin,
  output logic [63:0] sum,
  output logic        g
);

  logic [63:0] gen;
  logic [63:0] prop;
  logic        grp_carry;
  logic        bit_carry;
  logic        grp_g;
  logic        grp_p;
  logic        all_g;

  // 4-bit groups: carries ripple inside a group, and group generate/propagate skip between groups
  always_comb begin
    gen       = a & b;
    prop      = a ^ b;
    sum       = '0;
    grp_carry = cin;
    bit_carry = 1'b0;
    grp_g     = 1'b0;
    grp_p     = 1'b0;
    all_g     = 1'b0;
    for (int i = 0; i < 16; i++) begin
      grp_g = gen[4*i+3]
            | (prop[4*i+3] & gen[4*i+2])
            | (prop[4*i+3] & prop[4*i+2] & gen[4*i+1])
            | (prop[4*i+3] & prop[4*i+2] & prop[4*i+1] & gen[4*i]);
      grp_p = &prop[4*i +: 4];
      bit_carry = grp_carry;
      for (int k = 0; k < 4; k++) begin
        sum[4*i+k] = prop[4*i+k] ^ bit_carry;
        bit_carry  = gen[4*i+k] | (prop[4*i+k] & bit_carry);
      end
      grp_carry = grp_g | (grp_p & grp_carry);
      all_g     = grp_g | (grp_p & all_g);
    end
  end

  assign g = all_g;

endmodule

module sixtyfourbit_seq_mul (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [63:0] rs1,
  input  logic [63:0] rs2,
  output logic        busy,
  output logic        done,
  output logic [63:0] result
);

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;

  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

  state_t       state;
  state_t       state_nxt;
  logic [1:0]   op_q;
  logic [63:0]  mcand;
  logic [63:0]  mplier;
  logic [63:0]  acc_hi;
  logic [63:0]  acc_lo;
  logic [6:0]   count;
  logic         neg;

  logic         rs1_signed;
  logic         rs2_signed;
  logic [63:0]  rs1_mag;
  logic [63:0]  rs2_mag;
  logic         neg_in;
  logic [63:0]  add_sum;
  logic         add_g;
  logic [63:0]  step_sum;
  logic         step_carry;
  logic [127:0] prod;
  logic [127:0] prod_fixed;

  // Magnitudes are unsigned 64-bit, so |-2^63| = 2^63 falls out of plain negation
  assign rs1_signed = (op == OP_MULH) || (op == OP_MULHSU);
  assign rs2_signed = (op == OP_MULH);
  assign rs1_mag    = (rs1_signed && rs1[63]) ? (~rs1 + 64'd1) : rs1;
  assign rs2_mag    = (rs2_signed && rs2[63]) ? (~rs2 + 64'd1) : rs2;
  assign neg_in     = (op == OP_MULH)   ? (rs1[63] ^ rs2[63]) :
                      (op == OP_MULHSU) ? rs1[63] : 1'b0;

  sixtyfourbit_lca u_lca (
    .a   (acc_hi),
    .b   (mcand),
    .cin (1'b0),
    .sum (add_sum),
    .g   (add_g)
  );

  assign step_sum   = mplier[0] ? add_sum : acc_hi;
  assign step_carry = mplier[0] & add_g;
  assign prod       = {acc_hi, acc_lo};
  assign prod_fixed = neg ? (~prod + 128'd1) : prod;

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (count == 7'd63) state_nxt = SIGN;
      SIGN:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q   <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      count  <= '0;
      neg    <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q   <= op;
            mcand  <= rs1_mag;
            mplier <= rs2_mag;
            acc_hi <= '0;
            acc_lo <= '0;
            count  <= '0;
            neg    <= neg_in;
          end
        end
        CALC: begin
          acc_hi <= {step_carry, step_sum[63:1]};
          acc_lo <= {step_sum[0], acc_lo[63:1]};
          mplier <= {1'b0, mplier[63:1]};
          count  <= count + 7'd1;
        end
        SIGN: begin
          {acc_hi, acc_lo} <= prod_fixed;
          result <= (op_q == OP_MUL) ? prod_fixed[63:0] : prod_fixed[127:64];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sixtyfourbit_seq_mul.sv
// Directed bench for sixtyfourbit_seq_mul: hand-computed RV64M products,
// fixed latency, busy/done framing, ignored starts and reset abort.

module tb_sixtyfourbit_seq_mul;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;
  localparam logic [1:0] OP_MULHU  = 2'b11;

  localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MIN  = 64'h8000_0000_0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [63:0] rs1;
  logic [63:0] rs2;
  logic        busy;
  logic        done;
  logic [63:0] result;

  int checks = 0;
  int errors = 0;

  sixtyfourbit_seq_mul dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .rs1    (rs1),
    .rs2    (rs2),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%016h expected 0x%016h", tag, observed, expected);
    end
  endtask

  // Presents a request for one edge, then scrambles the inputs to show they are not re-sampled
  task automatic applyStimulus(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b);
    start = 1'b1;
    op    = o;
    rs1   = a;
    rs2   = b;
    tick(1);
    start = 1'b0;
    op    = ~o;
    rs1   = ~a;
    rs2   = b ^ 64'h5A5A_5A5A_5A5A_5A5A;
  endtask

  task automatic runOp(input string tag, input logic [1:0] o, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] expected);
    applyStimulus(o, a, b);
    checkOutput({tag, " busy after accept"}, {63'd0, busy}, 64'd1);
    tick(64);
    checkOutput({tag, " done early"}, {63'd0, done}, 64'd0);
    tick(1);
    checkOutput({tag, " done pulse"}, {63'd0, done}, 64'd1);
    checkOutput({tag, " result"}, result, expected);
    tick(1);
    checkOutput({tag, " done cleared"}, {63'd0, done}, 64'd0);
    checkOutput({tag, " busy cleared"}, {63'd0, busy}, 64'd0);
    checkOutput({tag, " result held"}, result, expected);
  endtask

  initial begin
    logic seen_done;
    rst   = 1'b1;
    start = 1'b0;
    op    = OP_MUL;
    rs1   = '0;
    rs2   = '0;
    tick(2);
    checkOutput("reset busy", {63'd0, busy}, 64'd0);
    checkOutput("reset done", {63'd0, done}, 64'd0);
    checkOutput("reset result", result, 64'd0);
    rst = 1'b0;
    tick(1);

    runOp("mul -1*-1", OP_MUL, ALL1, ALL1, 64'h0000_0000_0000_0001);
    runOp("mulhu -1*-1", OP_MULHU, ALL1, ALL1, 64'hFFFF_FFFF_FFFF_FFFE);
    runOp("mulh min*min", OP_MULH, MIN, MIN, 64'h4000_0000_0000_0000);
    runOp("mulhsu -1*max", OP_MULHSU, ALL1, ALL1, ALL1);
    runOp("mulh -3*7", OP_MULH, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7, ALL1);
    runOp("mul 3*5", OP_MUL, 64'd3, 64'd5, 64'd15);
    runOp("mulhu 2^32*2^32", OP_MULHU, 64'h1_0000_0000, 64'h1_0000_0000, 64'd1);
    runOp("mulh -1*-1", OP_MULH, ALL1, ALL1, 64'd0);
    runOp("mulhsu 2*max", OP_MULHSU, 64'd2, ALL1, 64'd1);
    runOp("mul 0*x", OP_MUL, 64'd0, 64'h1234_5678_9ABC_DEF0, 64'd0);
    runOp("mulh min*2", OP_MULH, MIN, 64'd2, ALL1);
    runOp("mul min*2", OP_MUL, MIN, 64'd2, 64'd0);

    // Second start mid-CALC and a start during DONE must both be ignored
    applyStimulus(OP_MULHU, ALL1, ALL1);
    tick(9);
    start = 1'b1;
    op    = OP_MUL;
    rs1   = 64'd3;
    rs2   = 64'd5;
    tick(1);
    start = 1'b0;
    checkOutput("busy start ignored", {63'd0, busy}, 64'd1);
    tick(54);
    checkOutput("busy late calc", {63'd0, busy}, 64'd1);
    checkOutput("ignored start done early", {63'd0, done}, 64'd0);
    tick(1);
    checkOutput("ignored start done pulse", {63'd0, done}, 64'd1);
    checkOutput("ignored start result", result, 64'hFFFF_FFFF_FFFF_FFFE);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    checkOutput("start in done ignored", {63'd0, busy}, 64'd0);
    tick(1);
    checkOutput("still idle after done start", {63'd0, busy}, 64'd0);
    checkOutput("result kept after done start", result, 64'hFFFF_FFFF_FFFF_FFFE);

    // Reset mid-CALC aborts without a done pulse
    applyStimulus(OP_MUL, 64'd3, 64'd5);
    tick(29);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    checkOutput("abort busy", {63'd0, busy}, 64'd0);
    checkOutput("abort done", {63'd0, done}, 64'd0);
    checkOutput("abort result", result, 64'd0);
    seen_done = 1'b0;
    for (int i = 0; i < 70; i++) begin
      tick(1);
      if (done) seen_done = 1'b1;
    end
    checkOutput("no done after abort", {63'd0, seen_done}, 64'd0);
    runOp("mul after abort", OP_MUL, 64'd3, 64'd5, 64'd15);

    // Reset wins over start on the same edge
    rst   = 1'b1;
    start = 1'b1;
    op    = OP_MULHU;
    rs1   = ALL1;
    rs2   = ALL1;
    tick(1);
    rst   = 1'b0;
    start = 1'b0;
    checkOutput("rst over start busy", {63'd0, busy}, 64'd0);
    checkOutput("rst over start result", result, 64'd0);
    tick(1);
    checkOutput("rst over start stays idle", {63'd0, busy}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sixtyfourbit_seq_mul.md
SIXTYFOURBIT_SEQ_MUL -- requirements
Module: sixtyfourbit_seq_mul

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock; all state SHALL update only on this edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 op  input  2  operation select: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU (RV64M encoding order).
REQ-006 rs1  input  64  multiplicand, sampled on the accepting edge.
REQ-007 rs2  input  64  multiplier, sampled on the accepting edge.
REQ-008 busy  output  1  high from the accepting edge until the edge that returns the block to IDLE.
REQ-009 done  output  1  single-cycle pulse marking result valid.
REQ-010 result  output  64  product: low half for MUL, high half otherwise.

Function
REQ-011 States SHALL be IDLE, CALC, SIGN and DONE, with no other reachable state.
REQ-012 IDLE with start=1 at edge E0 -> CALC; latch op; latch |rs1| and |rs2| per signedness; clear the 128-bit accumulator and the 7-bit iteration counter; latch neg = sign(rs1)^sign(rs2) for MULH, sign(rs1) for MULHSU, and 0 for MUL/MULHU.
REQ-013 Signedness SHALL be: MUL low result independent of sign; MULH both signed; MULHSU rs1 signed, rs2 unsigned; MULHU both unsigned.
REQ-014 CALC step, one per edge: if multiplier LSB=1, acc_hi += multiplicand; then shift {carry, acc_hi, acc_lo} right 1 bit and shift the multiplier right 1 bit.
REQ-015 The acc_hi += multiplicand addition SHALL use one sixtyfourbit_lca instance with carry-in 0; carry-out SHALL be taken from its g output.
REQ-016 CALC SHALL last exactly 64 edges (E1..E64); the counter SHALL reach 64 and then move to SIGN; there is no early termination.
REQ-017 SIGN (edge E65): if neg=1, acc = two's-complement negation of the 128-bit acc; then -> DONE, loading result with acc[63:0] for MUL or acc[127:64] otherwise.
REQ-018 DONE: done=1 for exactly the one cycle following E65; at edge E66 -> IDLE, busy=0.
REQ-019 Fixed latency: done SHALL be high in the 65th cycle after the accepting edge.
REQ-020 start while busy (CALC/SIGN/DONE) SHALL be ignored and SHALL NOT alter the latched operands.
REQ-021 start asserted in the DONE cycle SHALL be ignored; a new request SHALL be accepted only from IDLE, so back-to-back operations take 67 cycles each.
REQ-022 result SHALL hold its last value until the next SIGN->DONE load; rs1/rs2/op changes after acceptance SHALL have no effect.
REQ-023 Operands of 0 or -2^63 SHALL need no special-casing; |-2^63| = 2^63 SHALL be representable as a 64-bit unsigned magnitude.

Reset
REQ-024 rst=1 at any edge SHALL force IDLE and clear busy, done, result, the accumulator, the counter, neg and the latched op.
REQ-025 rst during CALC/SIGN/DONE SHALL abort the operation, with no done pulse for the aborted request.
REQ-026 rst SHALL take priority over start on the same edge.

Verification
REQ-027 MUL rs1=0xFFFF_FFFF_FFFF_FFFF, rs2=0xFFFF_FFFF_FFFF_FFFF -> result 0x0000_0000_0000_0001; done in cycle 65.
REQ-028 MULHU with both operands 0xFFFF_FFFF_FFFF_FFFF -> result 0xFFFF_FFFF_FFFF_FFFE.
REQ-029 MULH rs1=rs2=0x8000_0000_0000_0000 -> result 0x4000_0000_0000_0000.
REQ-030 MULHSU rs1=0xFFFF_FFFF_FFFF_FFFF (-1), rs2=0xFFFF_FFFF_FFFF_FFFF -> result 0xFFFF_FFFF_FFFF_FFFF; MULH rs1=-3, rs2=7 -> 0xFFFF_FFFF_FFFF_FFFF.
REQ-031 start pulsed again at cycle 10 of CALC with different operands -> ignored; the original result is returned at cycle 65; busy stays high throughout.
REQ-032 rst at cycle 30 of CALC -> next cycle busy=0, done=0, result=0; no done pulse for that request; a new start is then accepted normally.
